// File: rtl/mma_pkg.sv
// Shared types and constants for the MMA result drain path.
// Result elements are 4*P bits wide; the double buffer holds BUF_DEPTH matrices.
package mma_pkg;

  localparam int P_DEFAULT = 8;
  localparam int N_DEFAULT = 4;
  localparam int BUF_DEPTH = 2;

  // Accumulated result width for a given operand precision.
  function automatic int res_w(input int p);
    return 4 * p;
  endfunction

  localparam int RES_W = res_w(P_DEFAULT);

  typedef logic [RES_W-1:0]          res_elem_t;
  typedef res_elem_t [N_DEFAULT-1:0] row_vec_t;

endpackage

// File: rtl/mma_row_mux.sv
// Picks one row out of one matrix in the ping-pong pair.
module mma_row_mux
  import mma_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int RW = 32,
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic [BUF_DEPTH-1:0][M-1:0][N-1:0][RW-1:0] buf_pair,
  input  logic                                      rd_ptr,
  input  logic [IDX_W-1:0]                          row_idx,
  output logic [N-1:0][RW-1:0]                      row
);

  assign row = buf_pair[rd_ptr][row_idx];

endmodule

// File: rtl/mma_result_streamer.sv
// Drain side of the MMA datapath: captures whole result matrices into a
// two-entry ping-pong buffer and streams them out one row per beat.
// Optional feature: define MMA_RESULT_STREAMER_PARITY_EN to add out_parity
// (even parity per output element).
module mma_result_streamer
  import mma_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4,
  parameter int P = 8,
  localparam int RW = res_w(P),
  localparam int IDX_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         d_valid,
  output logic                         d_ready,
  input  logic [M-1:0][N-1:0][RW-1:0]  d_mat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0][RW-1:0]         out_row,
  output logic [IDX_W-1:0]             out_row_idx,
  output logic                         out_last
`ifdef MMA_RESULT_STREAMER_PARITY_EN
 ,output logic [N-1:0]                 out_parity
`endif
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(M - 1);

  logic [1:0]                                   count_q, count_d;
  logic                                         wr_ptr_q, wr_ptr_d;
  logic                                         rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]                             row_idx_q, row_idx_d;
  logic [BUF_DEPTH-1:0][M-1:0][N-1:0][RW-1:0]   buf_q, buf_d;

  logic capture;
  logic pop;
  logic pop_last;

  // Handshake status is a pure function of registered state, so there is no
  // combinational path from the input side to the output side.
  assign d_ready     = (count_q != 2'd2);
  assign out_valid   = (count_q != 2'd0);
  assign out_row_idx = row_idx_q;
  assign out_last    = out_valid && (row_idx_q == LAST_ROW);

  assign capture  = d_valid && d_ready;
  assign pop      = out_valid && out_ready;
  assign pop_last = pop && (row_idx_q == LAST_ROW);

  // Next-state: buffer write, pointer toggles, row walk and occupancy.
  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block leaves a
    // signal unassigned; otherwise synthesis would infer a latch.
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    row_idx_d = row_idx_q;
    buf_d     = buf_q;

    if (capture) begin
      buf_d[wr_ptr_q] = d_mat;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop) begin
      if (pop_last) begin
        row_idx_d = '0;
        rd_ptr_d  = ~rd_ptr_q;
      end else begin
        row_idx_d = row_idx_q + 1'b1;
      end
    end

    // A capture and a last-row pop in the same cycle cancel out.
    case ({capture, pop_last})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers, including both matrix buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      row_idx_q <= '0;
      // NOTE: the buffers are reset on purpose so out_row reads 0 after reset
      // rather than X; plain storage arrays normally carry no reset.
      buf_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      row_idx_q <= row_idx_d;
      buf_q     <= buf_d;
    end
  end

  mma_row_mux #(
    .M  (M),
    .N  (N),
    .RW (RW)
  ) u_row_mux (
    .buf_pair (buf_q),
    .rd_ptr   (rd_ptr_q),
    .row_idx  (row_idx_q),
    .row      (out_row)
  );

`ifdef MMA_RESULT_STREAMER_PARITY_EN
  // Even parity of each element of the row currently presented.
  always_comb begin
    out_parity = '0;
    for (int j = 0; j < N; j++) begin
      out_parity[j] = ^out_row[j];
    end
  end
`endif

endmodule

// File: tb/tb_mma_result_streamer.sv
// Directed bench for mma_result_streamer (M=2, N=2, P=8) with a beat scoreboard.
module tb_mma_result_streamer;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int P  = 8;
  localparam int RW = 4 * P;

  logic                        clk;
  logic                        rst_n;
  logic                        d_valid;
  logic                        d_ready;
  logic [M-1:0][N-1:0][RW-1:0] d_mat;
  logic                        out_valid;
  logic                        out_ready;
  logic [N-1:0][RW-1:0]        out_row;
  logic [0:0]                  out_row_idx;
  logic                        out_last;
`ifdef MMA_RESULT_STREAMER_PARITY_EN
  logic [N-1:0]                out_parity;
`endif

  mma_result_streamer #(.M(M), .N(N), .P(P)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_mat       (d_mat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last)
`ifdef MMA_RESULT_STREAMER_PARITY_EN
   ,.out_parity  (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][RW-1:0] row;
    logic [0:0]           idx;
    logic                 last;
  } beat_t;

  beat_t q[$];
  int    m_count;
  int    m_row;
  int    n_checks;
  int    n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [M-1:0][N-1:0][RW-1:0] mk(input logic [RW-1:0] a, b, c, d);
    logic [M-1:0][N-1:0][RW-1:0] m;
    m[0][0] = a; m[0][1] = b; m[1][0] = c; m[1][1] = d;
    return m;
  endfunction

  // Compare DUT outputs against the model; called at the falling edge.
  task automatic check_outputs();
    beat_t  e;
    check("out_valid", 64'(out_valid), 64'(m_count != 0));
    check("d_ready", 64'(d_ready), 64'(m_count != 2));
    if (m_count != 0 && q.size() > 0) begin
      e = q[0];
      check("out_row", 64'(out_row), 64'(e.row));
      check("out_row_idx", 64'(out_row_idx), 64'(e.idx));
      check("out_last", 64'(out_last), 64'(e.last));
`ifdef MMA_RESULT_STREAMER_PARITY_EN
      check("out_parity", 64'(out_parity), 64'({^e.row[1], ^e.row[0]}));
`endif
    end
  endtask

  // One clock: check, advance the model across the rising edge, return at falling edge.
  task automatic step();
    logic cap, pop, pl;
    check_outputs();
    cap = d_valid && (m_count != 2);
    pop = out_ready && (m_count != 0);
    pl  = pop && (m_row == M - 1);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_row = pl ? 0 : m_row + 1;
    end
    if (cap) begin
      for (int r = 0; r < M; r++) begin
        q.push_back('{row: d_mat[r], idx: 1'(r), last: (r == M - 1)});
      end
    end
    m_count = m_count + int'(cap) - int'(pl);
    @(negedge clk);
  endtask

  // Hold a matrix on the input until the model says it was taken.
  task automatic send(input logic [M-1:0][N-1:0][RW-1:0] m, input int max_cycles);
    bit taken;
    taken   = 1'b0;
    d_mat   = m;
    d_valid = 1'b1;
    for (int i = 0; i < max_cycles && !taken; i++) begin
      taken = (m_count != 2);
      step();
    end
    d_valid = 1'b0;
    check("send_taken", 64'(taken), 64'd1);
  endtask

  task automatic drain(input int max_cycles, input bit rand_ready);
    for (int i = 0; i < max_cycles && m_count != 0; i++) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    check("drain_empty", 64'(m_count), 64'd0);
    check_outputs();
  endtask

  task automatic model_reset();
    q.delete();
    m_count = 0;
    m_row   = 0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    model_reset();
    rst_n     = 1'b0;
    d_valid   = 1'b0;
    out_ready = 1'b0;
    d_mat     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset values.
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_d_ready", 64'(d_ready), 64'd1);
    check("rst_out_row", 64'(out_row), 64'd0);
    check("rst_out_row_idx", 64'(out_row_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
`ifdef MMA_RESULT_STREAMER_PARITY_EN
    check("rst_out_parity", 64'(out_parity), 64'd0);
`endif

    // Single matrix, downstream always ready.
    out_ready = 1'b1;
    send(mk(32'd1, 32'd2, 32'd3, 32'd4), 4);
    check("single_first_idx", 64'(out_row_idx), 64'd0);
    drain(10, 1'b0);

    // Two matrices with backpressure, then a third held while full.
    out_ready = 1'b0;
    send(mk(32'h11, 32'h12, 32'h13, 32'h14), 4);
    send(mk(32'h21, 32'h22, 32'h23, 32'h24), 4);
    check("full_d_ready", 64'(d_ready), 64'd0);
    d_mat   = mk(32'h31, 32'h32, 32'h33, 32'h34);
    d_valid = 1'b1;
    repeat (3) step();
    check("held_count", 64'(m_count), 64'd2);
    out_ready = 1'b1;
    send(mk(32'h31, 32'h32, 32'h33, 32'h34), 10);
    drain(20, 1'b0);

    // Capture coincident with the last-row pop at count 1.
    out_ready = 1'b1;
    send(mk(32'h41, 32'h42, 32'h43, 32'h44), 4);
    step();
    check("coinc_last_visible", 64'(out_last), 64'd1);
    send(mk(32'h51, 32'h52, 32'h53, 32'h54), 1);
    check("coinc_count", 64'(m_count), 64'd1);
    check("coinc_valid", 64'(out_valid), 64'd1);
    check("coinc_row0", 64'(out_row), {32'h52, 32'h51});
    drain(10, 1'b0);

    // Random stalls, bit-exact extreme values.
    out_ready = 1'b0;
    send(mk(32'hDEADBEEF, 32'h1, 32'hFFFFFFFF, 32'h0), 4);
    drain(60, 1'b1);

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    send(mk(32'h61, 32'h62, 32'h63, 32'h64), 4);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_d_ready", 64'(d_ready), 64'd1);
    check("mid_rst_out_row", 64'(out_row), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(mk(32'h71, 32'h72, 32'h73, 32'h74), 4);
    check("post_rst_idx", 64'(out_row_idx), 64'd0);
    drain(10, 1'b0);

`ifdef MMA_RESULT_STREAMER_PARITY_EN
    // Parity: element0 = 7 (odd weight), element1 = 3 (even weight).
    out_ready = 1'b0;
    send(mk(32'h7, 32'h3, 32'h0, 32'h1), 4);
    check("parity_row0", 64'(out_parity), 64'b01);
    drain(10, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
